// File: rtl/ewb_pkg.sv
// ewb_pkg: shared types and widths for the L2 eviction write buffer
package ewb_pkg;
  localparam int S_OFFSET = 5;
  localparam int S_LINE = 8 * 2**S_OFFSET;
  localparam int TAG_W = 32 - S_OFFSET;
  typedef enum logic [1:0] {IDLE, RESP, RD_MEM, DRAIN} ewb_state_t;
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [S_LINE-1:0] data;
  } ewb_entry_t;
  // a single-entry buffer still needs a 1-bit pointer
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/ewb_entry_array.sv
// ewb_entry_array: FIFO-ordered line storage with CAM lookup and in-place update
module ewb_entry_array
  import ewb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW = ptr_w(DEPTH),
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  tag,
  input  logic              upd,
  input  logic              push,
  input  logic              pop,
  input  logic [S_LINE-1:0] wdata,
  output logic              hit,
  output logic [PW-1:0]     hit_idx,
  output logic [S_LINE-1:0] hit_data,
  output logic [TAG_W-1:0]  head_tag,
  output logic [S_LINE-1:0] head_data,
  output logic [CW-1:0]     count,
  output logic              full
);
  ewb_entry_t ent [DEPTH];
  logic [PW-1:0] head, tail;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (DEPTH == 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent[i].valid && ent[i].tag == tag) begin
        hit = 1'b1;
        hit_idx = PW'(i);
      end
  end
  assign hit_data = ent[hit_idx].data;
  assign head_tag = ent[head].tag;
  assign head_data = ent[head].data;
  assign full = count == CW'(DEPTH);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (upd) ent[hit_idx].data <= wdata;
      if (push) begin
        ent[tail] <= {1'b1, tag, wdata};
        tail <= nxt(tail);
      end
      if (pop) begin
        ent[head].valid <= 1'b0;
        head <= nxt(head);
      end
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/l2_ewb.sv
// l2_ewb: eviction write buffer between L2 and memory; posts writes, serves read hits, drains when idle
module l2_ewb
  import ewb_pkg::*;
#(
  parameter int s_offset = S_OFFSET,
  parameter int s_line = S_LINE,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l2_read,
  input  logic              l2_write,
  input  logic [31:0]       l2_address,
  input  logic [s_line-1:0] l2_wdata,
  output logic [s_line-1:0] l2_rdata,
  output logic              l2_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [s_line-1:0] mem_wdata,
  input  logic [s_line-1:0] mem_rdata,
  input  logic              mem_resp
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  ewb_state_t state, next;
  logic [s_line-1:0] rdata_q, hit_data, head_data;
  logic [31-s_offset:0] head_tag;
  logic [PW-1:0] hit_idx;
  logic [CW-1:0] count;
  logic hit, full, upd, push, pop;
  ewb_entry_array #(.DEPTH(DEPTH)) u_arr (
    .clk(clk), .rst(rst), .tag(l2_address[31:s_offset]), .upd(upd), .push(push), .pop(pop),
    .wdata(l2_wdata), .hit(hit), .hit_idx(hit_idx), .hit_data(hit_data),
    .head_tag(head_tag), .head_data(head_data), .count(count), .full(full)
  );
  always_comb begin
    next = state;
    upd = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    case (state)
      IDLE:
        if (l2_read) next = hit ? RESP : RD_MEM;
        else if (l2_write) begin
          upd = hit;
          push = !hit && !full;
          next = (hit || !full) ? RESP : DRAIN;
        end else if (count != '0) next = DRAIN;
      RESP: next = IDLE;
      RD_MEM: next = mem_resp ? RESP : RD_MEM;
      DRAIN: begin
        pop = mem_resp;
        next = mem_resp ? IDLE : DRAIN;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata_q <= '0;
    else if (state == IDLE && l2_read && hit) rdata_q <= hit_data;
    else if (state == RD_MEM && mem_resp) rdata_q <= mem_rdata;
  assign l2_resp = state == RESP;
  assign l2_rdata = rdata_q;
  assign mem_read = state == RD_MEM;
  assign mem_write = state == DRAIN;
  assign mem_address = mem_read ? {l2_address[31:s_offset], {s_offset{1'b0}}} :
                       mem_write ? {head_tag, {s_offset{1'b0}}} : '0;
  assign mem_wdata = mem_write ? head_data : '0;
  assert property (@(posedge clk) disable iff (rst) !(l2_read && l2_write));
endmodule

// File: tb/tb_l2_ewb.sv
// tb_l2_ewb: randomized and directed bench with a line-level FIFO/memory reference model
module tb_l2_ewb;
  localparam int DEPTH = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic l2_read = 1'b0, l2_write = 1'b0, l2_resp, mem_read, mem_write, mem_resp;
  logic [31:0] l2_address = '0, mem_address;
  logic [255:0] l2_wdata = '0, l2_rdata, mem_wdata, mem_rdata;
  always #5 clk = ~clk;
  l2_ewb #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp), .mem_read(mem_read),
    .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );
  typedef struct { logic [26:0] tag; logic [255:0] data; } line_t;
  line_t q[$];
  line_t wb_log[$];
  logic [255:0] mem_store [logic [26:0]];
  int checks = 0, errors = 0, lat = 1, k = 0;
  function automatic logic [255:0] init_val(input logic [26:0] t);
    return {8{(32'(t) * 32'h9E3779B1) ^ 32'h5A5A0F0F}};
  endfunction
  function automatic logic [255:0] memval(input logic [26:0] t);
    return mem_store.exists(t) ? mem_store[t] : init_val(t);
  endfunction
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    chki("mem_rw_exclusive", int'(mem_read & mem_write), 0);
  endtask
  // memory: responds after lat cycles of a held request; write-backs must follow FIFO order
  initial begin
    mem_resp = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_resp = 1'b0;
        k = 0;
      end else if (mem_resp) mem_resp = 1'b0;
      else if (mem_read || mem_write) begin
        if (mem_write) begin
          chki("wb_pending", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            chki("wb_addr", mem_address, {q[0].tag, 5'b0});
            chk("wb_data", mem_wdata, q[0].data);
          end
        end
        k++;
        if (k >= lat) begin
          k = 0;
          mem_resp = 1'b1;
          if (mem_read) mem_rdata = memval(mem_address[31:5]);
          else begin
            mem_store[mem_address[31:5]] = mem_wdata;
            wb_log.push_back('{mem_address[31:5], mem_wdata});
            if (q.size() > 0) void'(q.pop_front());
          end
        end
      end
    end
  end
  task automatic do_req(input bit rd, input logic [31:0] a, input logic [255:0] d, input int l,
                        output int cyc, output int nrd, output int nwr, output logic [255:0] rdat);
    logic [26:0] t;
    logic [255:0] exp_d;
    int idx, exp_cyc, exp_rd, exp_wr, w;
    t = a[31:5];
    idx = -1;
    exp_rd = 0;
    exp_wr = 0;
    exp_d = '0;
    w = 0;
    while (mem_write && w < 100) begin
      tick;
      w++;
    end
    chki("drain_bound", int'(mem_write), 0);
    foreach (q[i]) if (q[i].tag == t) idx = i;
    lat = l;
    if (rd) begin
      exp_d = idx >= 0 ? q[idx].data : memval(t);
      exp_cyc = idx >= 0 ? 1 : l + 1;
      exp_rd = idx >= 0 ? 0 : l;
    end else if (idx >= 0) begin
      q[idx].data = d;
      exp_cyc = 1;
    end else begin
      exp_cyc = q.size() < DEPTH ? 1 : l + 2;
      exp_wr = q.size() < DEPTH ? 0 : l;
      q.push_back('{t, d});
    end
    l2_read = rd;
    l2_write = !rd;
    l2_address = a;
    l2_wdata = d;
    cyc = 0;
    nrd = 0;
    nwr = 0;
    do begin
      tick;
      cyc++;
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      if (mem_read) chki("mem_rd_addr", mem_address, {a[31:5], 5'b0});
    end while (!l2_resp && cyc < 200);
    rdat = l2_rdata;
    l2_read = 1'b0;
    l2_write = 1'b0;
    chki("resp_latency", cyc, exp_cyc);
    chki("mem_read_cycles", nrd, exp_rd);
    chki("mem_write_cycles", nwr, exp_wr);
    if (rd) chk("read_data", rdat, exp_d);
    tick;
    chki("resp_one_cycle", int'(l2_resp), 0);
  endtask
  task automatic flush;
    int w;
    w = 0;
    while ((q.size() > 0 || mem_write) && w < 500) begin
      tick;
      chki("idle_no_resp", int'(l2_resp), 0);
      w++;
    end
    chki("flush_done", q.size(), 0);
    repeat (3) tick;
    chki("flush_quiet", int'(mem_write | mem_read), 0);
  endtask
  task automatic chk_zero(input string name);
    chki({name, "_l2_resp"}, int'(l2_resp), 0);
    chki({name, "_mem_rd_wr"}, int'(mem_read | mem_write), 0);
    chki({name, "_mem_addr"}, mem_address, 0);
    chk({name, "_mem_wdata"}, mem_wdata, '0);
    chk({name, "_l2_rdata"}, l2_rdata, '0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int cyc, nrd, nwr, w;
    logic [255:0] rdat;
    logic [255:0] D0, D1, D2, D3, D4;
    D0 = {8{32'hD0D0_0001}};
    D1 = {8{32'hD1D1_0002}};
    D2 = {8{32'hD2D2_0003}};
    D3 = {8{32'hD3D3_0004}};
    D4 = {8{32'hD4D4_0005}};
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    tick;
    chk_zero("post_reset");
    wb_log.delete();
    do_req(0, 32'h1000, D0, 3, cyc, nrd, nwr, rdat);
    chki("t1_latency", cyc, 1);
    chki("t1_no_mem", nrd + nwr, 0);
    flush;
    chki("t1_wb_count", wb_log.size(), 1);
    chki("t1_wb_addr", {wb_log[0].tag, 5'b0}, 32'h1000);
    chk("t1_wb_data", wb_log[0].data, D0);
    do_req(0, 32'h2000, D1, 2, cyc, nrd, nwr, rdat);
    do_req(1, 32'h2004, '0, 2, cyc, nrd, nwr, rdat);
    chk("t2_rdata", rdat, D1);
    chki("t2_no_mem_read", nrd, 0);
    chki("t2_latency", cyc, 1);
    flush;
    wb_log.delete();
    do_req(0, 32'h40, D0, 2, cyc, nrd, nwr, rdat);
    do_req(0, 32'h80, D1, 2, cyc, nrd, nwr, rdat);
    do_req(0, 32'hC0, D2, 2, cyc, nrd, nwr, rdat);
    chki("t3_full_latency", cyc, 4);
    chki("t3_drain_cycles", nwr, 2);
    chki("t3_first_wb", {wb_log[0].tag, 5'b0}, 32'h40);
    flush;
    chki("t3_wb_count", wb_log.size(), 3);
    chki("t3_wb1", {wb_log[1].tag, 5'b0}, 32'h80);
    chki("t3_wb2", {wb_log[2].tag, 5'b0}, 32'hC0);
    do_req(1, 32'h3000, '0, 5, cyc, nrd, nwr, rdat);
    chki("t4_mem_read_held", nrd, 5);
    chki("t4_latency", cyc, 6);
    chk("t4_rdata", rdat, init_val(27'h180));
    wb_log.delete();
    do_req(0, 32'h40, D2, 2, cyc, nrd, nwr, rdat);
    do_req(0, 32'h40, D3, 2, cyc, nrd, nwr, rdat);
    chki("t5_coalesce_latency", cyc, 1);
    chki("t5_coalesce_no_mem", nrd + nwr, 0);
    flush;
    chki("t5_wb_count", wb_log.size(), 1);
    chk("t5_wb_data", wb_log[0].data, D3);
    do_req(0, 32'h40, D4, 20, cyc, nrd, nwr, rdat);
    w = 0;
    while (!mem_write && w < 10) begin
      tick;
      w++;
    end
    chki("t6_drain_started", int'(mem_write), 1);
    tick;
    #2 rst = 1'b1;
    #1 chki("t6_async_mem_write", int'(mem_write), 0);
    chki("t6_async_mem_addr", mem_address, 0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_zero("t6_after_reset");
    tick;
    do_req(1, 32'h40, '0, 3, cyc, nrd, nwr, rdat);
    chki("t6_read_to_mem", nrd, 3);
    chk("t6_rdata", rdat, D3);
    repeat (300) begin
      automatic bit rd = 1'($urandom_range(0, 1));
      automatic logic [31:0] a = 32'h10000 + ($urandom_range(0, 5) << 5) + $urandom_range(0, 31);
      automatic logic [255:0] d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_req(rd, a, d, $urandom_range(1, 4), cyc, nrd, nwr, rdat);
      repeat ($urandom_range(0, 3)) begin
        tick;
        chki("idle_no_resp", int'(l2_resp), 0);
      end
    end
    flush;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
